// File: rtl/trap_hit_monitor_pkg.sv
// Shared types and constants for the trap hit monitor: coordinate/colour widths,
// FSM state encoding and the saturating corner adder.
package trap_hit_monitor_pkg;

  localparam int COORD_W  = 9;
  localparam int COLOUR_W = 3;

  localparam logic [COORD_W-1:0]  SCREEN_MAX = 9'd511;
  localparam logic [COLOUR_W-1:0] NO_TRAP    = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROBE   = 3'd1,
    S_WAIT    = 3'd2,
    S_SAMPLE  = 3'd3,
    S_RESOLVE = 3'd4
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // One extra bit catches the carry; anything past the screen edge pins to SCREEN_MAX.
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W] ? SCREEN_MAX : sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/trap_hit_monitor_invuln_timer.sv
// Post-hit invulnerability down-counter; load wins over the decrement, settles at 0.
// active is high while the count is non-zero, starting the cycle after load.
module invuln_timer #(
  parameter int               INV_W   = 24,
  parameter logic [INV_W-1:0] INV_CYC = 24'd5000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  output logic active
);

  logic [INV_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= INV_CYC;
    end else if (count != '0) begin
      count <= count - {{(INV_W-1){1'b0}}, 1'b1};
    end
  end

  assign active = (count != '0);

endmodule

// File: rtl/trap_hit_monitor.sv
// Probes the four robot bounding-box corners through the trap map per new position
// and resolves hits; hit pulses 4*(TRAP_LAT+2)+1 clocks after pos_valid, which is dropped while busy.
module trap_hit_monitor
  import trap_hit_monitor_pkg::*;
#(
  parameter logic [8:0] ROBO_W   = 9'd10,
  parameter logic [8:0] ROBO_H   = 9'd10,
  parameter logic [1:0] LIVES    = 2'd3,
  parameter int         TRAP_LAT = 1,
  parameter int         INV_W    = 24,
  parameter logic [INV_W-1:0] INV_CYC = 24'd5000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                pos_valid,
  input  logic [COORD_W-1:0]  robot_x,
  input  logic [COORD_W-1:0]  robot_y,
  output logic [COORD_W-1:0]  probe_x,
  output logic [COORD_W-1:0]  probe_y,
  input  logic [COLOUR_W-1:0] trap_flag,
  output logic                busy,
  output logic                hit,
  output logic [COLOUR_W-1:0] hit_colour,
  output logic [1:0]          lives,
  output logic                invuln,
  output logic                game_over
);

  state_t              state, state_nxt;
  coord_t              pos;
  coord_t              corner;
  logic [COLOUR_W-1:0] acc;
  logic [1:0]          idx;
  logic [1:0]          wait_cnt;
  logic                accept;
  logic                take_hit;

  assign accept   = (state == S_IDLE) && pos_valid && !game_over;
  assign take_hit = (state == S_RESOLVE) && (acc != NO_TRAP) && !invuln;
  assign busy     = (state != S_IDLE);

  // idx bit 0 selects the right edge, bit 1 the bottom edge.
  always_comb begin
    corner = pos;
    if (idx[0]) corner.x = sat_add(pos.x, ROBO_W - 9'd1);
    if (idx[1]) corner.y = sat_add(pos.y, ROBO_H - 9'd1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_PROBE;
      S_PROBE:   state_nxt = S_WAIT;
      S_WAIT:    if (wait_cnt == 2'd1) state_nxt = S_SAMPLE;
      S_SAMPLE:  state_nxt = (idx == 2'd3) ? S_RESOLVE : S_PROBE;
      S_RESOLVE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pos        <= '0;
      acc        <= NO_TRAP;
      idx        <= 2'd0;
      wait_cnt   <= 2'd0;
      probe_x    <= '0;
      probe_y    <= '0;
      hit        <= 1'b0;
      hit_colour <= NO_TRAP;
      lives      <= LIVES;
      game_over  <= 1'b0;
    end else begin
      hit <= take_hit;
      case (state)
        S_IDLE: begin
          if (accept) begin
            pos <= '{x: robot_x, y: robot_y};
            acc <= NO_TRAP;
            idx <= 2'd0;
          end
        end
        S_PROBE: begin
          if (!game_over) begin
            probe_x <= corner.x;
            probe_y <= corner.y;
          end
          wait_cnt <= 2'(TRAP_LAT);
        end
        S_WAIT: wait_cnt <= wait_cnt - 2'd1;
        S_SAMPLE: begin
          acc <= acc | trap_flag;
          if (idx != 2'd3) idx <= idx + 2'd1;
        end
        default: ;
      endcase
      if (take_hit) begin
        hit_colour <= acc;
        if (lives != 2'd0) lives <= lives - 2'd1;
        if (lives == 2'd1) game_over <= 1'b1;
      end
    end
  end

  invuln_timer #(
    .INV_W   (INV_W),
    .INV_CYC (INV_CYC)
  ) u_invuln_timer (
    .clock  (clock),
    .resetn (resetn),
    .load   (take_hit),
    .active (invuln)
  );

endmodule

// File: tb/tb_trap_hit_monitor.sv
// Directed bench for trap_hit_monitor with a combinational trap-map model.
module tb_trap_hit_monitor;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pos_valid;
  logic [8:0] robot_x, robot_y;
  logic [8:0] probe_x, probe_y;
  logic [2:0] trap_flag;
  logic       busy, hit, invuln, game_over;
  logic [2:0] hit_colour;
  logic [1:0] lives;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0] cap_x[4];
  logic [8:0] cap_y[4];
  int         hit_at;
  int         hit_cnt;
  logic       busy_k12, busy_k13, busy_any;

  trap_hit_monitor #(
    .ROBO_W   (9'd10),
    .ROBO_H   (9'd10),
    .LIVES    (2'd3),
    .TRAP_LAT (1),
    .INV_W    (24),
    .INV_CYC  (24'd20)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pos_valid  (pos_valid),
    .robot_x    (robot_x),
    .robot_y    (robot_y),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .trap_flag  (trap_flag),
    .busy       (busy),
    .hit        (hit),
    .hit_colour (hit_colour),
    .lives      (lives),
    .invuln     (invuln),
    .game_over  (game_over)
  );

  always #5 clock = ~clock;

  // Trap map: one block of colour 100, plus a single colour-010 pixel in the far corner.
  assign trap_flag =
      ((probe_x >= 9'd75 && probe_x <= 9'd200 && probe_y >= 9'd236 && probe_y <= 9'd250) ? 3'b100 : 3'b000) |
      ((probe_x == 9'd511 && probe_y == 9'd511) ? 3'b010 : 3'b000);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Strobe one position, then observe 14 edges: probes at k=1,4,7,10, hit expected at k=13.
  task automatic do_pos(input logic [8:0] x, input logic [8:0] y, input bit poke);
    robot_x   = x;
    robot_y   = y;
    pos_valid = 1'b1;
    tick(1);
    pos_valid = 1'b0;
    hit_at    = -1;
    hit_cnt   = 0;
    busy_any  = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (poke && k == 3) begin
        robot_x   = 9'd10;
        robot_y   = 9'd10;
        pos_valid = 1'b1;
      end
      tick(1);
      pos_valid = 1'b0;
      if (hit) begin
        hit_cnt++;
        if (hit_at < 0) hit_at = k;
      end
      busy_any = busy_any | busy;
      if (k == 12) busy_k12 = busy;
      if (k == 13) busy_k13 = busy;
      if (k % 3 == 1 && k <= 10) begin
        cap_x[(k-1)/3] = probe_x;
        cap_y[(k-1)/3] = probe_y;
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    pos_valid = 1'b0;
    robot_x   = '0;
    robot_y   = '0;
    tick(2);
    resetn = 1'b1;

    // Reset state
    check("rst_probe_x", probe_x, 0);
    check("rst_probe_y", probe_y, 0);
    check("rst_busy", busy, 0);
    check("rst_hit", hit, 0);
    check("rst_hit_colour", hit_colour, 0);
    check("rst_lives", lives, 3);
    check("rst_invuln", invuln, 0);
    check("rst_game_over", game_over, 0);

    // No hit at (10,10)
    do_pos(9'd10, 9'd10, 1'b0);
    check("nohit_c0x", cap_x[0], 10);  check("nohit_c0y", cap_y[0], 10);
    check("nohit_c1x", cap_x[1], 19);  check("nohit_c1y", cap_y[1], 10);
    check("nohit_c2x", cap_x[2], 10);  check("nohit_c2y", cap_y[2], 19);
    check("nohit_c3x", cap_x[3], 19);  check("nohit_c3y", cap_y[3], 19);
    check("nohit_hit_at", hit_at, -1);
    check("nohit_lives", lives, 3);
    check("nohit_busy_resolve", busy_k12, 1);
    check("nohit_busy_drop", busy_k13, 0);

    // First hit at (70,230): only corner (79,239) lands in the trap
    do_pos(9'd70, 9'd230, 1'b0);
    check("hit1_c3x", cap_x[3], 79);
    check("hit1_c3y", cap_y[3], 239);
    check("hit1_at", hit_at, 13);
    check("hit1_pulse_len", hit_cnt, 1);
    check("hit1_colour", hit_colour, 3'b100);
    check("hit1_lives", lives, 2);
    check("hit1_invuln", invuln, 1);

    // Same position inside the invulnerability window
    do_pos(9'd70, 9'd230, 1'b0);
    check("inv_hit_at", hit_at, -1);
    check("inv_lives", lives, 2);
    check("inv_still_active", invuln, 1);
    tick(4);
    check("inv_expired", invuln, 0);

    // After expiry the same position hits again
    do_pos(9'd70, 9'd230, 1'b0);
    check("hit2_at", hit_at, 13);
    check("hit2_lives", lives, 1);
    check("hit2_game_over", game_over, 0);

    // Third hit ends the game
    tick(20);
    do_pos(9'd70, 9'd230, 1'b0);
    check("hit3_at", hit_at, 13);
    check("hit3_lives", lives, 0);
    check("hit3_game_over", game_over, 1);

    // Fourth position is ignored; everything frozen
    tick(20);
    do_pos(9'd10, 9'd10, 1'b0);
    check("go_busy", busy_any, 0);
    check("go_hit_at", hit_at, -1);
    check("go_lives", lives, 0);
    check("go_probe_x", probe_x, 79);
    check("go_probe_y", probe_y, 239);
    check("go_colour", hit_colour, 3'b100);
    check("go_sticky", game_over, 1);

    // Reset clears game over
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    check("rst2_lives", lives, 3);
    check("rst2_game_over", game_over, 0);

    // Saturating corners at (505,505), with a stray pos_valid mid-sequence
    do_pos(9'd505, 9'd505, 1'b1);
    check("sat_c0x", cap_x[0], 505);  check("sat_c0y", cap_y[0], 505);
    check("sat_c1x", cap_x[1], 511);  check("sat_c1y", cap_y[1], 505);
    check("sat_c2x", cap_x[2], 505);  check("sat_c2y", cap_y[2], 511);
    check("sat_c3x", cap_x[3], 511);  check("sat_c3y", cap_y[3], 511);
    check("sat_hit_at", hit_at, 13);
    check("sat_colour", hit_colour, 3'b010);
    check("sat_lives", lives, 2);

    // Reset during WAIT aborts the sequence
    tick(20);
    robot_x   = 9'd70;
    robot_y   = 9'd230;
    pos_valid = 1'b1;
    tick(1);
    pos_valid = 1'b0;
    tick(1);
    check("abort_busy_wait", busy, 1);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check("abort_busy", busy, 0);
    hit_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      if (hit) hit_cnt++;
    end
    check("abort_no_hit", hit_cnt, 0);
    check("abort_lives", lives, 3);
    check("abort_invuln", invuln, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
